multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/wait_timer.sv | 38 +++
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit:
// opcodes, ALU operation encodings and FSM states.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    function automatic logic op_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I, OP_BEQ, OP_JAL, OP_LOAD, OP_STORE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts cycles a memory request waits for its ack;
// expired flags that the wait limit has been reached.
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = (cnt_q == 8'(WAIT_MAX));

    // Clear when idle or acked; count unanswered request cycles, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !ack && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout, illegal-opcode retire and retired-instr counter.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branchtaken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_2_reg,
    output logic             reg_write,
    output logic             branch,
    output logic             jump,
    output logic             illegal_op,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       imem_req_c, dmem_req_c, ir_write_c, pc_write_c;
    logic [1:0] alu_op_c;
    logic       alu_src_c, mem_read_c, mem_write_c, mem_2_reg_c;
    logic       reg_write_c, branch_c, jump_c, illegal_c;

    logic t_run, t_ack, t_clear, t_expired;

    assign t_run   = imem_req_c | dmem_req_c;
    assign t_ack   = (state_q == S_FETCH) ? imem_ack : dmem_ack;
    assign t_clear = !t_run || t_ack;

    wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (t_clear),
        .run    (t_run),
        .ack    (t_ack),
        .expired(t_expired)
    );

    // Next-state and control decode from state, latched opcode and acks.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        alu_op_c    = ALU_ADD;
        alu_src_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_2_reg_c = 1'b0;
        reg_write_c = 1'b0;
        branch_c    = 1'b0;
        jump_c      = 1'b0;
        illegal_c   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (t_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                if (op_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_c  = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        alu_op_c = ALU_RTYPE;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        alu_src_c = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c   = ALU_SUB;
                        branch_c   = branchtaken;
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_JAL: begin
                        jump_c     = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req_c  = 1'b1;
                mem_read_c  = (opcode_q == OP_LOAD);
                mem_write_c = (opcode_q == OP_STORE);
                if (dmem_ack) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (t_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                mem_2_reg_c = (opcode_q == OP_LOAD);
                pc_write_c  = 1'b1;
                state_d     = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
    end

    // Sticky error flag and retired-instruction counter.
    always_comb begin
        err_d = err_q | (state_d == S_ERROR);
        cnt_d = cnt_q;
        if (pc_write_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req    = imem_req_c  & ~rst;
    assign dmem_req    = dmem_req_c  & ~rst;
    assign ir_write    = ir_write_c  & ~rst;
    assign pc_write    = pc_write_c  & ~rst;
    assign alu_op      = rst ? 2'b00 : alu_op_c;
    assign alu_src     = alu_src_c   & ~rst;
    assign mem_read    = mem_read_c  & ~rst;
    assign mem_write   = mem_write_c & ~rst;
    assign mem_2_reg   = mem_2_reg_c & ~rst;
    assign reg_write   = reg_write_c & ~rst;
    assign branch      = branch_c    & ~rst;
    assign jump        = jump_c      & ~rst;
    assign illegal_op  = illegal_c   & ~rst;
    assign err         = err_q       & ~rst;
    assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit
// (WAIT_MAX=4, CNT_W=2).
module tb_multicycle_control_unit;
    import ctrl_pkg::*;

    localparam logic [14:0] IREQ = 15'h4000;
    localparam logic [14:0] DREQ = 15'h2000;
    localparam logic [14:0] IRW  = 15'h1000;
    localparam logic [14:0] PCW  = 15'h0800;
    localparam logic [14:0] ALU1 = 15'h0400;
    localparam logic [14:0] ALU0 = 15'h0200;
    localparam logic [14:0] ASRC = 15'h0100;
    localparam logic [14:0] MRD  = 15'h0080;
    localparam logic [14:0] MWR  = 15'h0040;
    localparam logic [14:0] M2R  = 15'h0020;
    localparam logic [14:0] RW   = 15'h0010;
    localparam logic [14:0] BR   = 15'h0008;
    localparam logic [14:0] JMP  = 15'h0004;
    localparam logic [14:0] ILL  = 15'h0002;
    localparam logic [14:0] ERR  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       branchtaken;
    logic       imem_ack, dmem_ack;
    logic       imem_req, dmem_req, ir_write, pc_write;
    logic [1:0] alu_op;
    logic       alu_src, mem_read, mem_write, mem_2_reg;
    logic       reg_write, branch, jump, illegal_op, err;
    logic [1:0] instr_count;

    int         nchk = 0;
    int         nerr = 0;
    logic [1:0] exp_cnt = 2'd0;

    multicycle_control_unit #(
        .WAIT_MAX(4),
        .CNT_W   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .branchtaken(branchtaken),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_2_reg  (mem_2_reg),
        .reg_write  (reg_write),
        .branch     (branch),
        .jump       (jump),
        .illegal_op (illegal_op),
        .err        (err),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] outs();
        return {imem_req, dmem_req, ir_write, pc_write, alu_op,
                alu_src, mem_read, mem_write, mem_2_reg, reg_write,
                branch, jump, illegal_op, err};
    endfunction

    task automatic apply_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 2'd0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        opcode   = OP_R;
        @(posedge clk);
        @(negedge clk);
        nchk++;
        if (outs() !== NONE) begin
            nerr++;
            $display("FAIL reset_outs got=%h exp=%h", outs(), NONE);
        end
        nchk++;
        if (instr_count !== 2'd0) begin
            nerr++;
            $display("FAIL reset_cnt got=%0d exp=0", instr_count);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        nchk++;
        if (outs() !== IREQ) begin
            nerr++;
            $display("FAIL reset_release got=%h exp=%h", outs(), IREQ);
        end
    endtask

    task automatic test_rtype();
        logic [14:0] e [4];
        e = '{IREQ | IRW, NONE, ALU1, RW | PCW};
        opcode = OP_R;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            dmem_ack = 1'b1;
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL rtype c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        exp_cnt  = exp_cnt + 2'd1;
        nchk++;
        if (instr_count !== exp_cnt) begin
            nerr++;
            $display("FAIL rtype_cnt got=%0d exp=%0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_load_delay();
        logic [14:0] e [8];
        e = '{IREQ | IRW, NONE, ASRC, DREQ | MRD, DREQ | MRD,
              DREQ | MRD, DREQ | MRD, RW | M2R | PCW};
        opcode = OP_LOAD;
        for (int i = 0; i < 8; i++) begin
            imem_ack = (i == 0);
            dmem_ack = (i == 6);
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL load c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        exp_cnt  = exp_cnt + 2'd1;
        nchk++;
        if (instr_count !== exp_cnt) begin
            nerr++;
            $display("FAIL load_cnt got=%0d exp=%0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_beq();
        logic [14:0] e [6];
        e = '{IREQ | IRW, NONE, ALU0 | BR | PCW,
              IREQ | IRW, NONE, ALU0 | PCW};
        opcode = OP_BEQ;
        for (int i = 0; i < 6; i++) begin
            imem_ack    = (i == 0) || (i == 3);
            branchtaken = (i < 3);
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL beq c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        branchtaken = 1'b0;
        exp_cnt     = exp_cnt + 2'd2;
        nchk++;
        if (instr_count !== exp_cnt) begin
            nerr++;
            $display("FAIL beq_cnt got=%0d exp=%0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e [11];
        logic [6:0]  op [11];
        e  = '{IREQ | IRW, NONE, ASRC, RW | PCW,
               IREQ | IRW, NONE, JMP | PCW,
               IREQ | IRW, NONE, ASRC, DREQ | MWR | PCW};
        op = '{OP_I, OP_I, OP_I, OP_I,
               OP_JAL, OP_JAL, OP_JAL,
               OP_STORE, OP_STORE, OP_STORE, OP_STORE};
        for (int i = 0; i < 11; i++) begin
            opcode   = op[i];
            imem_ack = (i == 0) || (i == 4) || (i == 7);
            dmem_ack = (i == 10);
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL b2b c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_cnt  = exp_cnt + 2'd3;
        nchk++;
        if (instr_count !== exp_cnt) begin
            nerr++;
            $display("FAIL b2b_cnt got=%0d exp=%0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [14:0] e [2];
        e = '{IREQ | IRW, ILL | PCW};
        opcode = 7'b1111111;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 2; i++) begin
                imem_ack = (i == 0);
                @(negedge clk);
                nchk++;
                if (outs() !== e[i]) begin
                    nerr++;
                    $display("FAIL illegal n%0d c%0d got=%h exp=%h",
                             n, i + 1, outs(), e[i]);
                end
                @(posedge clk);
                #1;
            end
        end
        imem_ack = 1'b0;
        nchk++;
        if (instr_count !== 2'd1) begin
            nerr++;
            $display("FAIL illegal_wrap got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_ack_wins();
        logic [14:0] e [7];
        e = '{IREQ, IREQ, IREQ, IREQ, IREQ | IRW, NONE, JMP | PCW};
        apply_reset();
        opcode = OP_JAL;
        for (int i = 0; i < 7; i++) begin
            imem_ack = (i == 4);
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL ackwin c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        nchk++;
        if (instr_count !== 2'd1) begin
            nerr++;
            $display("FAIL ackwin_cnt got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_timeout();
        logic [14:0] exp_v;
        apply_reset();
        opcode = OP_R;
        for (int i = 0; i < 25; i++) begin
            exp_v    = (i < 5) ? IREQ : ERR;
            imem_ack = (i >= 5) && i[0];
            dmem_ack = (i >= 5);
            @(negedge clk);
            nchk++;
            if (outs() !== exp_v) begin
                nerr++;
                $display("FAIL timeout c%0d got=%h exp=%h", i + 1, outs(), exp_v);
            end
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        nchk++;
        if (outs() !== NONE) begin
            nerr++;
            $display("FAIL timeout_rst got=%h exp=%h", outs(), NONE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if (outs() !== IREQ) begin
            nerr++;
            $display("FAIL timeout_recover got=%h exp=%h", outs(), IREQ);
        end
    endtask

    task automatic test_rst_mid_store();
        logic [14:0] e [5];
        e = '{IREQ | IRW, NONE, ASRC, DREQ | MWR, DREQ | MWR};
        apply_reset();
        opcode = OP_STORE;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 0);
            dmem_ack = 1'b0;
            @(negedge clk);
            nchk++;
            if (outs() !== e[i]) begin
                nerr++;
                $display("FAIL store c%0d got=%h exp=%h", i + 1, outs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        nchk++;
        if (outs() !== NONE) begin
            nerr++;
            $display("FAIL store_rst got=%h exp=%h", outs(), NONE);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        nchk++;
        if (outs() !== IREQ) begin
            nerr++;
            $display("FAIL store_after got=%h exp=%h", outs(), IREQ);
        end
        nchk++;
        if (instr_count !== 2'd0) begin
            nerr++;
            $display("FAIL store_cnt got=%0d exp=0", instr_count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        opcode      = OP_R;
        branchtaken = 1'b0;
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        test_reset();
        apply_reset();
        test_rtype();
        test_load_delay();
        test_beq();
        test_back_to_back();
        apply_reset();
        test_illegal();
        test_ack_wins();
        test_timeout();
        test_rst_mid_store();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
